// File: rtl/uart_tx_framer_if.sv
// Write-side bus of uart_tx_framer: push strobe and data word in, FIFO status out.
interface uart_tx_framer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              we;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (output we, data_in, input full, empty, count, overflow);
    modport slave  (input we, data_in, output full, empty, count, overflow);
endinterface

// File: rtl/uart_tx_framer.sv
// Word FIFO, baud timing and UART character framer with optional CRC-8 trailer per frame.
module uart_tx_framer #(
    parameter int CLK_DIV   = 2320,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1,
    parameter int FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_framer_if.slave wr,
    input  logic [1:0]      parity_mode,
    input  logic            crc_en,
    output logic            tx,
    output logic            busy,
    output logic            tx_done,
    output logic [7:0]      crc
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int BAUD_W = $clog2(2 * CLK_DIV);
    localparam int FCNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [BAUD_W-1:0] BIT_LAST   = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST  = BAUD_W'(STOP_BITS * CLK_DIV - 1);
    localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAME_LEN - 1);
    localparam logic [2:0]        DATA_LAST  = 3'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CRC_START
    } state_t;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] d);
        case (mode)
            2'b01:   return ^d;
            2'b10:   return ~^d;
            default: return 1'b1;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          sh_q, sh_d;
    logic [1:0]          par_mode_q, par_mode_d;
    logic                par_bit_q, par_bit_d;
    logic                is_crc_q, is_crc_d;
    logic [7:0]          crc_q, crc_d;
    logic                crc_en_q, crc_en_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic       full, empty, push, pop;
    logic       bit_end, stop_end, frame_end, go_crc, frame_clr;
    logic [7:0] head8, crc_base;

    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (cnt_q == '0);
    assign bit_end   = (baud_q == BIT_LAST);
    assign stop_end  = (state_q == S_STOP) && (baud_q == STOP_LAST);
    assign frame_end = stop_end && !is_crc_q && (fcnt_q == FRAME_LAST);
    assign go_crc    = frame_end && crc_en_q;
    // A frame closes either at its last data character (no trailer) or after the trailer.
    assign frame_clr = (frame_end && !crc_en_q) || (stop_end && is_crc_q);
    assign pop       = !empty && ((state_q == S_IDLE) || (stop_end && !go_crc));
    assign push      = wr.we && (!full || pop);

    always_comb begin
        head8 = '0;
        head8[DATA_W-1:0] = mem[rptr_q];
    end

    // FIFO bookkeeping
    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (wr.we && !push);
    end

    // Frame counter and running CRC; a pop on a frame boundary starts the new frame from 0x00.
    always_comb begin
        fcnt_d = fcnt_q;
        if (stop_end && !is_crc_q) fcnt_d = fcnt_q + 1'b1;
        if (frame_clr)             fcnt_d = '0;
        crc_base = frame_clr ? 8'h00 : crc_q;
        crc_d    = pop ? crc8_step(crc_base, head8) : crc_base;
        crc_en_d = (pop && (fcnt_d == '0)) ? crc_en : crc_en_q;
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        par_mode_d = par_mode_q;
        par_bit_d  = par_bit_q;
        is_crc_d   = is_crc_q;
        case (state_q)
            S_IDLE: baud_d = '0;
            S_START, S_CRC_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    sh_d   = sh_q >> 1;
                    if (bit_q == (is_crc_q ? 3'd7 : DATA_LAST)) begin
                        state_d = (par_mode_q == 2'b00) ? S_STOP : S_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                end
            end
            S_STOP: begin
                if (stop_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            state_d    = S_START;
            baud_d     = '0;
            sh_d       = head8;
            par_mode_d = parity_mode;
            par_bit_d  = parity_bit(parity_mode, head8);
            is_crc_d   = 1'b0;
        end else if (go_crc) begin
            state_d   = S_CRC_START;
            baud_d    = '0;
            sh_d      = crc_q;
            par_bit_d = parity_bit(par_mode_q, crc_q);
            is_crc_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            par_mode_q <= '0;
            is_crc_q   <= 1'b0;
            crc_q      <= '0;
            crc_en_q   <= 1'b0;
            fcnt_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            par_mode_q <= par_mode_d;
            is_crc_q   <= is_crc_d;
            crc_q      <= crc_d;
            crc_en_q   <= crc_en_d;
            fcnt_q     <= fcnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q      <= sh_d;
        par_bit_q <= par_bit_d;
        if (push) mem[wptr_q] <= wr.data_in;
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START, S_CRC_START: tx = 1'b0;
            S_DATA:               tx = sh_q[0];
            S_PARITY:             tx = par_bit_q;
            default:              tx = 1'b1;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign tx_done     = stop_end;
    assign crc         = crc_q;
    assign wr.full     = full;
    assign wr.empty    = empty;
    assign wr.count    = cnt_q;
    assign wr.overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench: two framer configurations, serial-line monitors decode tx against queued expectations.
module tb_uart_tx_framer;
    localparam int CDIV = 4;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         par;
        int         stops;
    } exp_t;

    logic clk;
    logic reset_a, reset_b;
    logic [1:0] pm_a, pm_b;
    logic ce_a, ce_b;
    logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
    logic [7:0] crc_a, crc_b;
    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    uart_tx_framer_if #(.DATA_W(8), .DEPTH(4)) bus_a ();
    uart_tx_framer_if #(.DATA_W(5), .DEPTH(4)) bus_b ();

    uart_tx_framer #(.CLK_DIV(CDIV), .DATA_W(8), .DEPTH(4), .STOP_BITS(1), .FRAME_LEN(4)) dut_a (
        .clk(clk), .reset(reset_a), .wr(bus_a), .parity_mode(pm_a), .crc_en(ce_a),
        .tx(tx_a), .busy(busy_a), .tx_done(done_a), .crc(crc_a));

    uart_tx_framer #(.CLK_DIV(CDIV), .DATA_W(5), .DEPTH(4), .STOP_BITS(2), .FRAME_LEN(1)) dut_b (
        .clk(clk), .reset(reset_b), .wr(bus_b), .parity_mode(pm_b), .crc_en(ce_b),
        .tx(tx_b), .busy(busy_b), .tx_done(done_b), .crc(crc_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] d, input int nb, input int p, input int s);
        exp_t e;
        e.data = d; e.nbits = nb; e.par = p; e.stops = s;
        return e;
    endfunction

    function automatic logic get_tx(input int k);    return (k == 0) ? tx_a : tx_b; endfunction
    function automatic logic get_busy(input int k);  return (k == 0) ? busy_a : busy_b; endfunction
    function automatic logic get_done(input int k);  return (k == 0) ? done_a : done_b; endfunction
    function automatic logic get_rst(input int k);   return (k == 0) ? reset_a : reset_b; endfunction
    function automatic logic get_empty(input int k); return (k == 0) ? bus_a.empty : bus_b.empty; endfunction
    function automatic int   qsize(input int k);     return (k == 0) ? q_a.size() : q_b.size(); endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Decode one character per start bit; every cycle of the frame is compared.
    task automatic mon(input int k);
        exp_t e;
        logic bits [0:15];
        logic [7:0] got;
        int nb, total, bad_cyc;
        bit aborted, bad_bits, bad_done;
        forever begin
            @(negedge clk);
            if (get_rst(k) && get_tx(k) == 1'b0) begin
                if (qsize(k) == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_char dut%0d: got a start bit, expected idle line", k);
                    for (int w = 0; w < 200 && get_tx(k) == 1'b0; w++) @(negedge clk);
                end else begin
                    e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
                    bits[0] = 1'b0; nb = 1;
                    for (int i = 0; i < e.nbits; i++) begin bits[nb] = e.data[i]; nb++; end
                    if (e.par >= 0) begin bits[nb] = e.par[0]; nb++; end
                    for (int i = 0; i < e.stops; i++) begin bits[nb] = 1'b1; nb++; end
                    total = nb * CDIV;
                    aborted = 0; bad_bits = 0; bad_done = 0; bad_cyc = -1; got = '0;
                    for (int c = 0; c < total; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!get_rst(k)) begin aborted = 1; break; end
                        if (get_tx(k) !== bits[c / CDIV] || get_busy(k) !== 1'b1) begin
                            if (!bad_bits) bad_cyc = c;
                            bad_bits = 1;
                        end
                        if (get_done(k) !== (c == total - 1)) bad_done = 1;
                        if ((c % CDIV) == CDIV / 2 && c / CDIV >= 1 && c / CDIV <= e.nbits)
                            got[c / CDIV - 1] = get_tx(k);
                    end
                    if (!aborted) begin
                        checks++;
                        if (bad_bits) begin
                            errors++;
                            $display("FAIL char_wave dut%0d: got data %02h, expected %02h (first differing cycle %0d)",
                                     k, got, e.data, bad_cyc);
                        end
                        checks++;
                        if (bad_done) begin
                            errors++;
                            $display("FAIL tx_done_pulse dut%0d char %02h: got pulse off cycle %0d, expected only there",
                                     k, e.data, total - 1);
                        end
                    end
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic wr(input int k, input logic [7:0] d);
        if (k == 0) begin bus_a.we = 1'b1; bus_a.data_in = d; end
        else begin bus_b.we = 1'b1; bus_b.data_in = d[4:0]; end
        @(posedge clk); #1;
        bus_a.we = 1'b0;
        bus_b.we = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, output int n);
        n = 0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (get_done(k)) n++;
            if (qsize(k) == 0 && !get_busy(k) && get_empty(k)) break;
            if (cyc >= budget) begin
                checks++; errors++;
                $display("FAIL idle_timeout dut%0d: got still busy after %0d cycles, expected idle", k, budget);
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int k, input int want, input int budget);
        int n;
        n = 0;
        for (int cyc = 0; cyc < budget && n < want; cyc++) begin
            @(negedge clk);
            if (get_done(k)) n++;
        end
        if (n < want) begin
            checks++; errors++;
            $display("FAIL done_timeout dut%0d: got %0d tx_done pulses, expected %0d", k, n, want);
        end
    endtask

    initial begin
        logic [1:0] modes [3];
        int pars [3];
        int n;
        modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
        pars[0] = 1; pars[1] = 0; pars[2] = 1;

        reset_a = 1'b0; reset_b = 1'b0;
        pm_a = 2'b00; pm_b = 2'b00; ce_a = 1'b0; ce_b = 1'b0;
        bus_a.we = 1'b0; bus_a.data_in = '0;
        bus_b.we = 1'b0; bus_b.data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_empty", 32'(bus_a.empty), 1);
        chk("rst_full", 32'(bus_a.full), 0);
        chk("rst_count", 32'(bus_a.count), 0);
        chk("rst_overflow", 32'(bus_a.overflow), 0);
        chk("rst_crc", 32'(crc_a), 0);
        chk("rst_tx_b", 32'(tx_b), 1);
        reset_a = 1'b1; reset_b = 1'b1;
        @(posedge clk); #1;

        // 0x55, no parity: launch latency and waveform
        q_a.push_back(mk(8'h55, 8, -1, 1));
        wr(0, 8'h55);
        chk("launch_tx_still_high", 32'(tx_a), 1);
        chk("launch_count_1", 32'(bus_a.count), 1);
        @(posedge clk); #1;
        chk("launch_tx_low", 32'(tx_a), 0);
        chk("launch_busy", 32'(busy_a), 1);
        chk("launch_count_0", 32'(bus_a.count), 0);
        wait_idle(0, 200, n);
        chk("char55_pulses", 32'(n), 1);
        chk("char55_busy_after", 32'(busy_a), 0);

        // 0x07 under even, odd and mark parity
        for (int i = 0; i < 3; i++) begin
            pm_a = modes[i];
            q_a.push_back(mk(8'h07, 8, pars[i], 1));
            wr(0, 8'h07);
            wait_idle(0, 200, n);
            chk("parity_pulses", 32'(n), 1);
        end
        pm_a = 2'b00;

        // CRC frame 01..04 -> trailer 0xE3
        ce_a = 1'b1;
        q_a.push_back(mk(8'h01, 8, -1, 1));
        q_a.push_back(mk(8'h02, 8, -1, 1));
        q_a.push_back(mk(8'h03, 8, -1, 1));
        q_a.push_back(mk(8'h04, 8, -1, 1));
        q_a.push_back(mk(8'hE3, 8, -1, 1));
        wr(0, 8'h01); wr(0, 8'h02); wr(0, 8'h03); wr(0, 8'h04);
        ce_a = 1'b0;
        wait_pulses(0, 4, 400);
        chk("crc_value_e3", 32'(crc_a), 32'hE3);
        wait_pulses(0, 1, 100);
        @(negedge clk);
        chk("crc_cleared", 32'(crc_a), 0);
        wait_idle(0, 100, n);
        chk("crc_no_extra_pulse", 32'(n), 0);

        // Overflow while a character is in flight
        q_a.push_back(mk(8'h3C, 8, -1, 1));
        wr(0, 8'h3C);
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) q_a.push_back(mk(8'(8'h10 + i), 8, -1, 1));
            wr(0, 8'(8'h10 + i));
            if (i == 3) begin
                chk("ovf_full_after_4", 32'(bus_a.full), 1);
                chk("ovf_count_4", 32'(bus_a.count), 4);
                chk("ovf_not_yet", 32'(bus_a.overflow), 0);
            end
        end
        chk("ovf_sticky", 32'(bus_a.overflow), 1);
        chk("ovf_count_still_4", 32'(bus_a.count), 4);
        wait_pulses(0, 1, 100);
        q_a.push_back(mk(8'h16, 8, -1, 1));
        bus_a.we = 1'b1; bus_a.data_in = 8'h16;
        @(posedge clk); #1;
        bus_a.we = 1'b0;
        chk("push_on_pop_count", 32'(bus_a.count), 4);
        chk("push_on_pop_full", 32'(bus_a.full), 1);
        wait_idle(0, 600, n);
        chk("ovf_chars_sent", 32'(n), 5);

        // Asynchronous reset during data bit 3 (0x96 has bit 3 = 0)
        q_a.push_back(mk(8'h96, 8, -1, 1));
        wr(0, 8'h96);
        n = 0;
        for (int w = 0; w < 20 && tx_a !== 1'b0; w++) @(negedge clk);
        chk("rst_mid_started", 32'(tx_a), 0);
        repeat (18) @(negedge clk);
        #1 reset_a = 1'b0;
        #1;
        chk("rst_mid_tx", 32'(tx_a), 1);
        chk("rst_mid_count", 32'(bus_a.count), 0);
        chk("rst_mid_crc", 32'(crc_a), 0);
        chk("rst_mid_busy", 32'(busy_a), 0);
        chk("rst_mid_overflow", 32'(bus_a.overflow), 0);
        repeat (2) @(negedge clk);
        reset_a = 1'b1;
        @(posedge clk); #1;
        q_a.push_back(mk(8'hA5, 8, -1, 1));
        wr(0, 8'hA5);
        wait_idle(0, 200, n);
        chk("post_rst_pulses", 32'(n), 1);

        // 5-bit words, 2 stop bits, CRC after every word
        ce_b = 1'b1;
        q_b.push_back(mk(8'h1F, 5, -1, 2));
        q_b.push_back(mk(8'h5D, 8, -1, 2));
        wr(1, 8'h1F);
        @(posedge clk); #1;
        chk("b_crc_1f", 32'(crc_b), 32'h5D);
        wait_idle(1, 200, n);
        chk("b_pulses_1f", 32'(n), 2);
        chk("b_crc_cleared", 32'(crc_b), 0);
        pm_b = 2'b10;
        q_b.push_back(mk(8'h0A, 5, 1, 2));
        q_b.push_back(mk(8'h36, 8, 1, 2));
        wr(1, 8'h0A);
        @(posedge clk); #1;
        chk("b_crc_0a", 32'(crc_b), 32'h36);
        wait_idle(1, 200, n);
        chk("b_pulses_0a", 32'(n), 2);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised successor to the switch-to-FIFO-to-UART transmit path.
- Merges into one clocked block: a write-side FIFO, an integrated baud generator, a character framer (configurable data width, parity mode and stop bits) and an optional CRC-8 trailer appended after every FRAME_LEN data words.
- Sits between any word producer (switch capture, test pattern generator) and the board TX pin.
- Replaces the separate FIFO, FIFO-to-out and out-to-com chain, and the toggled divided clock.

Parameters:
- CLK_DIV, 2320, clk cycles per bit period; range 2..4095.
- DATA_W, 8, data bits per character; range 5..8.
- DEPTH, 16, FIFO depth in words; must be a power of 2, at least 2.
- STOP_BITS, 1, stop bits per character; 1 or 2.
- FRAME_LEN, 4, data words per CRC frame; range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- we  in  1  write strobe; data_in is pushed when we=1.
- data_in  in  DATA_W  word to transmit.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (always 1).
- crc_en  in  1  when 1, append a CRC character after each frame.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: set when a write is dropped; cleared only by reset.
- tx  out  1  serial line; idle high.
- busy  out  1  FSM not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit of every character, CRC character included.
- crc  out  8  running CRC of the current frame.

Behaviour:
Reset (async, reset=0):
- tx=1, busy=0, tx_done=0, empty=1, full=0, count=0, overflow=0, crc=0x00.
- FSM goes to IDLE; FIFO pointers, frame counter and baud counter are cleared.
- Takes effect immediately, including mid-character; tx returns high without completing the character.

FIFO:
- Write is accepted when we=1 and (not full, or a pop occurs in the same cycle).
- Otherwise the word is dropped and overflow is set.
- A simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH.

Launch:
- When the FSM is in IDLE and empty=0 at a rising edge, that edge pops the head word, latches parity_mode, loads the shift register and enters START with tx=0.
- A word written into an empty idle block therefore drives tx low 2 edges after the we edge.

FSM states and sequence: IDLE -> START -> DATA -> PARITY -> STOP -> (IDLE | CRC_START).
- Each bit lasts exactly CLK_DIV cycles, counted by a baud counter running 0..CLK_DIV-1 and reset at every state entry.
- DATA shifts out DATA_W bits, LSB first.
- PARITY is skipped when the latched mode is 00.
- Parity bit value: even = XOR of the data bits; odd = its inverse; mark = 1.
- STOP lasts STOP_BITS x CLK_DIV cycles with tx=1.
- tx_done pulses on the final cycle of STOP.
- busy stays 1 through the whole character.
- Back-to-back characters: when the FIFO is non-empty at the end of STOP, the next START begins on the next cycle, with no idle gap.

CRC:
- Polynomial 0x07, init 0x00, MSB-first, not reflected.
- Updated over each data word zero-extended to 8 bits, on the cycle that word is popped.
- crc_en is latched when the first word of a frame is popped.
- A frame counter increments at the end of STOP of each data character.
- After the FRAME_LEN-th data character:
  - If the latched crc_en=1, the FSM enters CRC_START and sends the 8-bit CRC as one character. It always has 8 data bits regardless of DATA_W, uses the latched parity mode, and is followed by STOP.
  - Then crc clears to 0x00 and the frame counter clears.
  - If the latched crc_en=0, both clear at the same frame boundary and nothing is appended.
- The CRC character is never taken from the FIFO; FIFO writes continue normally while it is sent.

Input changes mid-character:
- Changing parity_mode or crc_en affects only the next character or frame, respectively.

Test Plan:
- CLK_DIV=4, DATA_W=8, parity 00, STOP_BITS=1: write 0x55 -> tx low 2 edges after we; tx = 0,1,0,1,0,1,0,1,0,1 for 4 cycles each; tx_done pulses once at cycle 40 of the character; busy=0 afterwards.
- Write 0x07 with parity 01 -> parity bit 1; repeat with parity 10 -> parity bit 0; repeat with parity 11 -> parity bit 1. Each character is 11 bits = 44 cycles.
- crc_en=1, FRAME_LEN=4: write 0x01, 0x02, 0x03, 0x04 -> four data characters followed by CRC character 0xE3 (bits 1,1,0,0,0,1,1,1); crc returns to 0x00 after its STOP; 5 tx_done pulses in total.
- DEPTH=4, FSM stalled in a long character: write 6 words -> full=1 after 4 writes, count=4, overflow=1; exactly 4 words transmitted. Push while full on a pop edge -> accepted, count stays 4.
- Assert reset=0 during DATA bit 3 -> tx=1 with no clock edge; count=0, crc=0x00. After release, the next write is transmitted as a complete fresh character.
- DATA_W=5, STOP_BITS=2: write 0x1F -> 1 start + 5 data + 2 stop = 8 bit periods; the upper data_in bits are unused and CRC uses the zero-extended value 0x1F.
